// File: rtl/wb_stage_skid.sv
// Writeback pipeline stage: NUM_LANES records behind a 2-entry skid buffer with a registered in_ready.
// Optional forwarding port from the MAIN entry is enabled by defining WB_STAGE_FWD_EN.
module wb_stage_skid #(
   parameter int unsigned NUM_LANES = 1,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 5
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush_i,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic [NUM_LANES*ADDR_W-1:0]   in_rd_i,
   input  logic [NUM_LANES*DATA_W-1:0]   in_wdata_i,
   input  logic [NUM_LANES-1:0]          in_wreg_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [NUM_LANES*ADDR_W-1:0]   out_rd_o,
   output logic [NUM_LANES*DATA_W-1:0]   out_wdata_o,
   output logic [NUM_LANES-1:0]          out_wreg_o
`ifdef WB_STAGE_FWD_EN
   ,
   input  logic [ADDR_W-1:0]             fwd_raddr_i,
   output logic                          fwd_hit_o,
   output logic [DATA_W-1:0]             fwd_data_o
`endif
);

   localparam int unsigned RdW = NUM_LANES * ADDR_W;
   localparam int unsigned DW  = NUM_LANES * DATA_W;

   logic                 main_valid_q, main_valid_d;
   logic [RdW-1:0]       main_rd_q, main_rd_d;
   logic [DW-1:0]        main_wdata_q, main_wdata_d;
   logic [NUM_LANES-1:0] main_wreg_q, main_wreg_d;
   logic                 skid_valid_q, skid_valid_d;
   logic [RdW-1:0]       skid_rd_q, skid_rd_d;
   logic [DW-1:0]        skid_wdata_q, skid_wdata_d;
   logic [NUM_LANES-1:0] skid_wreg_q, skid_wreg_d;
   logic                 in_ready_q, in_ready_d;

   logic                 xfer_in, xfer_out;
   logic [NUM_LANES-1:0] in_wreg_m;

   assign xfer_in  = in_valid_i & in_ready_q;
   assign xfer_out = main_valid_q & out_ready_i;

   // Writes to x0 are dropped at capture so the register file never sees them.
   always_comb begin
      in_wreg_m = '0;
      for (int i = 0; i < int'(NUM_LANES); i++) begin
         in_wreg_m[i] = in_wreg_i[i] & (in_rd_i[i*ADDR_W +: ADDR_W] != '0);
      end
   end

   always_comb begin
      main_valid_d = main_valid_q;
      main_rd_d    = main_rd_q;
      main_wdata_d = main_wdata_q;
      main_wreg_d  = main_wreg_q;
      skid_valid_d = skid_valid_q;
      skid_rd_d    = skid_rd_q;
      skid_wdata_d = skid_wdata_q;
      skid_wreg_d  = skid_wreg_q;

      if (flush_i) begin
         main_valid_d = 1'b0;
         main_rd_d    = '0;
         main_wdata_d = '0;
         main_wreg_d  = '0;
         skid_valid_d = 1'b0;
         skid_rd_d    = '0;
         skid_wdata_d = '0;
         skid_wreg_d  = '0;
      end else if (!main_valid_q || xfer_out) begin
         if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_rd_d    = skid_rd_q;
            main_wdata_d = skid_wdata_q;
            main_wreg_d  = skid_wreg_q;
            skid_valid_d = 1'b0;
         end else if (xfer_in) begin
            main_valid_d = 1'b1;
            main_rd_d    = in_rd_i;
            main_wdata_d = in_wdata_i;
            main_wreg_d  = in_wreg_m;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (xfer_in) begin
         skid_valid_d = 1'b1;
         skid_rd_d    = in_rd_i;
         skid_wdata_d = in_wdata_i;
         skid_wreg_d  = in_wreg_m;
      end

      in_ready_d = ~skid_valid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_rd_q    <= '0;
         main_wdata_q <= '0;
         main_wreg_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_rd_q    <= '0;
         skid_wdata_q <= '0;
         skid_wreg_q  <= '0;
         in_ready_q   <= 1'b1;
      end else begin
         main_valid_q <= main_valid_d;
         main_rd_q    <= main_rd_d;
         main_wdata_q <= main_wdata_d;
         main_wreg_q  <= main_wreg_d;
         skid_valid_q <= skid_valid_d;
         skid_rd_q    <= skid_rd_d;
         skid_wdata_q <= skid_wdata_d;
         skid_wreg_q  <= skid_wreg_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = main_valid_q;
   assign out_rd_o    = main_rd_q;
   assign out_wdata_o = main_wdata_q;
   assign out_wreg_o  = main_wreg_q;

`ifdef WB_STAGE_FWD_EN
   // Ascending scan so the highest-index matching lane wins.
   always_comb begin
      fwd_hit_o  = 1'b0;
      fwd_data_o = '0;
      for (int i = 0; i < int'(NUM_LANES); i++) begin
         if (main_valid_q && main_wreg_q[i] && (fwd_raddr_i != '0) &&
             (main_rd_q[i*ADDR_W +: ADDR_W] == fwd_raddr_i)) begin
            fwd_hit_o  = 1'b1;
            fwd_data_o = main_wdata_q[i*DATA_W +: DATA_W];
         end
      end
   end
`endif

endmodule

// File: tb/tb_wb_stage_skid.sv
// Scoreboard bench for wb_stage_skid with two lanes; forwarding checks build only with
// WB_STAGE_FWD_EN defined.
module tb_wb_stage_skid;

   localparam int unsigned NL = 2;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [9:0]    in_rd, out_rd;
   logic [63:0]   in_wdata, out_wdata;
   logic [1:0]    in_wreg, out_wreg;
`ifdef WB_STAGE_FWD_EN
   logic [4:0]    fwd_raddr;
   logic          fwd_hit;
   logic [31:0]   fwd_data;
`endif

   typedef struct {
      logic [9:0]  rd;
      logic [63:0] wdata;
      logic [1:0]  wreg;
      int          cyc;
   } rec_t;

   rec_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   bit   chk_lat = 1'b0;
   bit   acc;

   wb_stage_skid #(.NUM_LANES(NL), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_rd_i     (in_rd),
      .in_wdata_i  (in_wdata),
      .in_wreg_i   (in_wreg),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_rd_o    (out_rd),
      .out_wdata_o (out_wdata),
      .out_wreg_o  (out_wreg)
`ifdef WB_STAGE_FWD_EN
      ,
      .fwd_raddr_i (fwd_raddr),
      .fwd_hit_o   (fwd_hit),
      .fwd_data_o  (fwd_data)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] mask_wreg(input logic [9:0] rd, input logic [1:0] wr);
      mask_wreg[0] = wr[0] & (rd[4:0] != 5'd0);
      mask_wreg[1] = wr[1] & (rd[9:5] != 5'd0);
   endfunction

   task automatic drive(input logic [9:0] rd, input logic [63:0] wd, input logic [1:0] wr);
      in_valid = 1'b1;
      in_rd    = rd;
      in_wdata = wd;
      in_wreg  = wr;
   endtask

   // Sample handshakes on the falling edge, then advance one cycle.
   task automatic tick();
      rec_t e;
      acc = 1'b0;
      if (!rst && flush) begin
         sb.delete();
      end else if (!rst) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check_eq("spurious_out", 128'(out_valid), 128'(0));
            end else begin
               e = sb.pop_front();
               check_eq("out_rec", {out_rd, out_wdata, out_wreg}, {e.rd, e.wdata, e.wreg});
               if (chk_lat) check_eq("latency", 128'(cyc - e.cyc), 128'(1));
            end
         end
         if (in_valid && in_ready) begin
            acc = 1'b1;
            e.rd = in_rd; e.wdata = in_wdata; e.wreg = mask_wreg(in_rd, in_wreg); e.cyc = cyc;
            sb.push_back(e);
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(10'h3ff, 64'hffff_ffff_ffff_ffff, 2'b11);
`ifdef WB_STAGE_FWD_EN
      fwd_raddr = 5'd0;
`endif
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0; in_valid = 1'b0;
      check_eq("rst_out_valid", 128'(out_valid), 128'(0));
      check_eq("rst_in_ready", 128'(in_ready), 128'(1));
      check_eq("rst_out_wreg", 128'(out_wreg), 128'(0));
      check_eq("rst_out_wdata", 128'(out_wdata), 128'(0));
      check_eq("rst_out_rd", 128'(out_rd), 128'(0));
      tick();

      // Streaming at full rate, one-cycle latency.
      out_ready = 1'b1; chk_lat = 1'b1;
      for (int k = 0; k < 8; k++) begin
         drive({5'(k + 8), 5'(k)}, {32'(32'h200 + k), 32'(32'h100 + k)}, 2'b11);
         check_eq("stream_in_ready", 128'(in_ready), 128'(1));
         if (k > 0) check_eq("stream_out_valid", 128'(out_valid), 128'(1));
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk_lat = 1'b0;
      check_eq("stream_drained", 128'(sb.size()), 128'(0));
      check_eq("stream_idle_valid", 128'(out_valid), 128'(0));

      // Backpressure: A in MAIN, B in SKID, C held upstream.
      out_ready = 1'b0;
      drive({5'd1, 5'd10}, {32'hA1A1_0001, 32'hA0A0_0000}, 2'b11);
      tick();
      drive({5'd2, 5'd11}, {32'hB1B1_0001, 32'hB0B0_0000}, 2'b01);
      tick();
      check_eq("bp_in_ready_full", 128'(in_ready), 128'(0));
      drive({5'd3, 5'd12}, {32'hC1C1_0001, 32'hC0C0_0000}, 2'b10);
      tick();
      tick();
      check_eq("bp_in_ready_hold", 128'(in_ready), 128'(0));
      check_eq("bp_out_valid", 128'(out_valid), 128'(1));
      check_eq("bp_out_is_a", {out_rd, out_wdata, out_wreg},
               {10'({5'd1, 5'd10}), 64'({32'hA1A1_0001, 32'hA0A0_0000}), 2'b11});
      check_eq("bp_sb_depth", 128'(sb.size()), 128'(2));
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         check_eq("bp_drain_valid", 128'(out_valid), 128'(1));
         tick();
         if (acc) in_valid = 1'b0;
      end
      check_eq("bp_drained", 128'(sb.size()), 128'(0));
      check_eq("bp_c_taken", 128'(in_valid), 128'(0));

      // Write to x0 on lane 0 must be masked; data passes unchanged.
      drive({5'd7, 5'd0}, {32'h1234_5678, 32'hDEAD_BEEF}, 2'b11);
      tick();
      in_valid = 1'b0;
      check_eq("x0_out_valid", 128'(out_valid), 128'(1));
      check_eq("x0_out_wreg", 128'(out_wreg), 128'(2'b10));
      check_eq("x0_out_wdata", 128'(out_wdata[31:0]), 128'(32'hDEAD_BEEF));
      tick();

      // Flush with both entries full and a record presented.
      out_ready = 1'b0;
      drive({5'd4, 5'd20}, 64'h4444_0000_4040_0000, 2'b11);
      tick();
      drive({5'd5, 5'd21}, 64'h5555_0000_5050_0000, 2'b11);
      tick();
      drive({5'd6, 5'd22}, 64'h6666_0000_6060_0000, 2'b11);
      flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check_eq("fl_out_valid", 128'(out_valid), 128'(0));
      check_eq("fl_in_ready", 128'(in_ready), 128'(1));
      check_eq("fl_out_wdata", 128'(out_wdata), 128'(0));
      check_eq("fl_out_wreg", 128'(out_wreg), 128'(0));
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check_eq("fl_no_output", 128'(out_valid), 128'(0));
      end

`ifdef WB_STAGE_FWD_EN
      out_ready = 1'b0;
      drive({5'd3, 5'd3}, {32'h22, 32'h11}, 2'b11);
      tick();
      in_valid = 1'b0;
      fwd_raddr = 5'd3; #1;
      check_eq("fwd_hit3", 128'(fwd_hit), 128'(1));
      check_eq("fwd_data3", 128'(fwd_data), 128'(32'h22));
      fwd_raddr = 5'd4; #1;
      check_eq("fwd_hit4", 128'(fwd_hit), 128'(0));
      check_eq("fwd_data4", 128'(fwd_data), 128'(0));
      fwd_raddr = 5'd0; #1;
      check_eq("fwd_hit0", 128'(fwd_hit), 128'(0));
      out_ready = 1'b1;
      tick();
`endif

      check_eq("sb_empty_end", 128'(sb.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
